// File: rtl/min_pair_scheduler_pkg.sv
// Shared types and defaults for the min-pair scheduler.
// Contents: scan state enum, default symbol count / frequency width,
// statistics counter width.
package huff_pkg;

   localparam int unsigned DEFAULT_NUM_SYMBOLS = 8;
   localparam int unsigned DEFAULT_FREQ_WIDTH  = 9;
   localparam int unsigned CMP_COUNT_W         = 16;

   // Scan sequencer states, in encoding order.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN1  = 3'd1,
      WAIT1  = 3'd2,
      SCAN2  = 3'd3,
      WAIT2  = 3'd4,
      FINISH = 3'd5
   } state_e;

endpackage

// File: rtl/min_pair_scheduler_if.sv
// Bundle between the min-pair scheduler, its host and the external comparator.
// master: host side (start/inputs/comparator responses), reads results.
// slave : scheduler side.
// Optional: MINPAIR_STATS_EN adds the 16-bit cmp_count result.
interface min_pair_scheduler_if
   import huff_pkg::*;
#(
   parameter int unsigned NUM_SYMBOLS = DEFAULT_NUM_SYMBOLS,
   parameter int unsigned FREQ_WIDTH  = DEFAULT_FREQ_WIDTH
);
   localparam int unsigned IDX_W = $clog2(NUM_SYMBOLS);

   logic                              start;
   logic                              busy;
   logic [NUM_SYMBOLS*FREQ_WIDTH-1:0] freq_vec;
   logic [NUM_SYMBOLS-1:0]            valid_mask;
   logic                              cmp_start;
   logic [FREQ_WIDTH-1:0]             cmp_a;
   logic [FREQ_WIDTH-1:0]             cmp_b;
   logic [31:0]                       cmp_num_of_bits;
   logic                              cmp_done;
   logic                              cmp_equal;
   logic                              cmp_greater;
   logic                              cmp_less;
   logic                              done;
   logic                              error;
   logic [IDX_W-1:0]                  min1_idx;
   logic [IDX_W-1:0]                  min2_idx;
   logic [FREQ_WIDTH-1:0]             min1_freq;
   logic [FREQ_WIDTH-1:0]             min2_freq;
`ifdef MINPAIR_STATS_EN
   logic [CMP_COUNT_W-1:0]            cmp_count;
`endif

   modport master (
      output start, freq_vec, valid_mask, cmp_done, cmp_equal, cmp_greater, cmp_less,
      input  busy, cmp_start, cmp_a, cmp_b, cmp_num_of_bits, done, error,
             min1_idx, min2_idx, min1_freq, min2_freq
`ifdef MINPAIR_STATS_EN
      , input cmp_count
`endif
   );

   modport slave (
      input  start, freq_vec, valid_mask, cmp_done, cmp_equal, cmp_greater, cmp_less,
      output busy, cmp_start, cmp_a, cmp_b, cmp_num_of_bits, done, error,
             min1_idx, min2_idx, min1_freq, min2_freq
`ifdef MINPAIR_STATS_EN
      , output cmp_count
`endif
   );

endinterface

// File: rtl/min_pair_scheduler.sv
// Finds the two smallest live frequencies (lowest index wins ties) using an
// external handshaked comparator: pass 1 finds min1, pass 2 repeats without
// the min1 index. Fewer than two live entries finishes at once with error.
// Ports: clk, reset (async, active low), if_bus (slave modport: start/busy,
// freq_vec/valid_mask, cmp_* handshake, done/error/min1_*/min2_*).
// Optional: MINPAIR_STATS_EN adds cmp_count (completed compares, saturating).
module min_pair_scheduler
   import huff_pkg::*;
#(
   parameter int unsigned NUM_SYMBOLS = DEFAULT_NUM_SYMBOLS,
   parameter int unsigned FREQ_WIDTH  = DEFAULT_FREQ_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   min_pair_scheduler_if.slave if_bus
);
   localparam int unsigned      IDX_W    = $clog2(NUM_SYMBOLS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYMBOLS - 1);

   state_e                 r_state, w_state_nxt;
   logic [FREQ_WIDTH-1:0]  r_freq [NUM_SYMBOLS];
   logic [NUM_SYMBOLS-1:0] r_mask;
   logic [IDX_W-1:0]       r_idx, r_cand_idx, r_min1_idx;
   logic [FREQ_WIDTH-1:0]  r_cand_freq, r_min1_freq;
   logic                   r_have_cand;
   logic                   r_busy, r_done, r_error, r_cmp_start;
   logic [FREQ_WIDTH-1:0]  r_cmp_a, r_cmp_b;
   logic [IDX_W-1:0]       r_res_min1_idx, r_res_min2_idx;
   logic [FREQ_WIDTH-1:0]  r_res_min1_freq, r_res_min2_freq;

   logic w_accept, w_multi, w_scan, w_wait, w_pass2, w_live, w_last;
   logic w_set_cand, w_issue, w_cmp_ret, w_adv, w_take;
   logic [IDX_W-1:0]      w_cand_idx_n;
   logic [FREQ_WIDTH-1:0] w_cand_freq_n;
   logic                  w_unused_cmp;

   assign w_accept = (r_state == IDLE) && if_bus.start;
   // At least two bits set iff clearing the lowest set bit leaves something.
   assign w_multi  = |(if_bus.valid_mask & (if_bus.valid_mask - NUM_SYMBOLS'(1)));
   assign w_scan   = (r_state == SCAN1) || (r_state == SCAN2);
   assign w_wait   = (r_state == WAIT1) || (r_state == WAIT2);
   assign w_pass2  = (r_state == SCAN2) || (r_state == WAIT2);
   assign w_live   = r_mask[r_idx] && !(w_pass2 && (r_idx == r_min1_idx));
   assign w_last   = (r_idx == LAST_IDX);
   // Only the less-than flag steers the search.
   assign w_unused_cmp = &{1'b0, if_bus.cmp_equal, if_bus.cmp_greater};

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:         if (if_bus.start) w_state_nxt = w_multi ? SCAN1 : FINISH;
         SCAN1, WAIT1: if (w_issue)      w_state_nxt = WAIT1;
                       else if (w_adv)   w_state_nxt = w_last ? SCAN2 : SCAN1;
         SCAN2, WAIT2: if (w_issue)      w_state_nxt = WAIT2;
                       else if (w_adv)   w_state_nxt = w_last ? FINISH : SCAN2;
         FINISH:       w_state_nxt = IDLE;
         default:      w_state_nxt = IDLE;
      endcase
   end

   // Output/control decode: first live index seeds the candidate, later ones compare.
   always_comb begin
      w_set_cand = 1'b0;
      w_issue    = 1'b0;
      w_cmp_ret  = 1'b0;
      w_adv      = 1'b0;
      if (w_scan) begin
         if (w_live && r_have_cand) begin
            w_issue = 1'b1;
         end else begin
            w_adv      = 1'b1;
            w_set_cand = w_live;
         end
      end else if (w_wait && if_bus.cmp_done) begin
         w_cmp_ret = 1'b1;
         w_adv     = 1'b1;
      end
      w_take        = w_set_cand || (w_cmp_ret && if_bus.cmp_less);
      w_cand_idx_n  = w_take ? r_idx : r_cand_idx;
      w_cand_freq_n = w_take ? r_freq[r_idx] : r_cand_freq;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SYMBOLS; i++) r_freq[i] <= '0;
         r_mask          <= '0;
         r_idx           <= '0;
         r_cand_idx      <= '0;
         r_cand_freq     <= '0;
         r_min1_idx      <= '0;
         r_min1_freq     <= '0;
         r_have_cand     <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_error         <= 1'b0;
         r_cmp_start     <= 1'b0;
         r_cmp_a         <= '0;
         r_cmp_b         <= '0;
         r_res_min1_idx  <= '0;
         r_res_min2_idx  <= '0;
         r_res_min1_freq <= '0;
         r_res_min2_freq <= '0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (w_state_nxt == FINISH);
         if (w_accept) begin
            for (int unsigned i = 0; i < NUM_SYMBOLS; i++)
               r_freq[i] <= if_bus.freq_vec[i*FREQ_WIDTH +: FREQ_WIDTH];
            r_mask      <= if_bus.valid_mask;
            r_idx       <= '0;
            r_have_cand <= 1'b0;
            if (!w_multi) begin
               r_error         <= 1'b1;
               r_res_min1_idx  <= '0;
               r_res_min2_idx  <= '0;
               r_res_min1_freq <= '0;
               r_res_min2_freq <= '0;
            end
         end
         if (w_issue) begin
            r_cmp_start <= 1'b1;
            r_cmp_a     <= r_freq[r_idx];
            r_cmp_b     <= r_cand_freq;
         end
         if (w_cmp_ret) r_cmp_start <= 1'b0;
         if (w_take) begin
            r_cand_idx  <= w_cand_idx_n;
            r_cand_freq <= w_cand_freq_n;
            r_have_cand <= 1'b1;
         end
         if (w_adv) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) begin
               r_have_cand <= 1'b0;
               if (!w_pass2) begin
                  r_min1_idx  <= w_cand_idx_n;
                  r_min1_freq <= w_cand_freq_n;
               end else begin
                  r_error         <= 1'b0;
                  r_res_min1_idx  <= r_min1_idx;
                  r_res_min1_freq <= r_min1_freq;
                  r_res_min2_idx  <= w_cand_idx_n;
                  r_res_min2_freq <= w_cand_freq_n;
               end
            end
         end
      end
   end

`ifdef MINPAIR_STATS_EN
   logic [CMP_COUNT_W-1:0] r_cmp_count;

   // Completed-compare counter, cleared per accepted start, saturating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmp_count <= '0;
      end else if (w_accept) begin
         r_cmp_count <= '0;
      end else if (w_cmp_ret && (r_cmp_count != {CMP_COUNT_W{1'b1}})) begin
         r_cmp_count <= r_cmp_count + CMP_COUNT_W'(1);
      end
   end

   assign if_bus.cmp_count = r_cmp_count;
`endif

   assign if_bus.busy            = r_busy;
   assign if_bus.done            = r_done;
   assign if_bus.error           = r_error;
   assign if_bus.cmp_start       = r_cmp_start;
   assign if_bus.cmp_a           = r_cmp_a;
   assign if_bus.cmp_b           = r_cmp_b;
   assign if_bus.cmp_num_of_bits = 32'(FREQ_WIDTH);
   assign if_bus.min1_idx        = r_res_min1_idx;
   assign if_bus.min2_idx        = r_res_min2_idx;
   assign if_bus.min1_freq       = r_res_min1_freq;
   assign if_bus.min2_freq       = r_res_min2_freq;

endmodule

// File: tb/tb_min_pair_scheduler.sv
// Bench for min_pair_scheduler: random-latency comparator model, reference
// min-pair model feeding a scoreboard queue, checked when done pulses.
module tb_min_pair_scheduler;
   localparam int N = 8;
   localparam int W = 9;

   typedef struct {
      int i1, i2, f1, f2, err, ncmp;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_err = 0;
   int   n_checks = 0;
   int   n_cmp = 0;
   exp_t exp_q [$];

   always #5 clk = ~clk;

   min_pair_scheduler_if #(.NUM_SYMBOLS(N), .FREQ_WIDTH(W)) bus ();

   min_pair_scheduler #(.NUM_SYMBOLS(N), .FREQ_WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .if_bus (bus)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int fget(input logic [N*W-1:0] fv, input int i);
      return int'(fv[i*W +: W]);
   endfunction

   // Reference: smallest live value, lowest index on ties; then again without it.
   function automatic exp_t model(input logic [N*W-1:0] fv, input logic [N-1:0] m);
      exp_t e;
      int live = 0;
      int i1 = -1;
      int i2 = -1;
      for (int i = 0; i < N; i++) if (m[i]) live++;
      e = '{default: 0};
      if (live < 2) begin
         e.err = 1;
         return e;
      end
      for (int i = 0; i < N; i++)
         if (m[i] && (i1 < 0 || fget(fv, i) < fget(fv, i1))) i1 = i;
      for (int i = 0; i < N; i++)
         if (m[i] && i != i1 && (i2 < 0 || fget(fv, i) < fget(fv, i2))) i2 = i;
      e.i1 = i1; e.i2 = i2;
      e.f1 = fget(fv, i1); e.f2 = fget(fv, i2);
      e.ncmp = 2 * live - 3;
      return e;
   endfunction

   // Comparator model: random 1..6 cycle latency, checks operand stability and gap.
   initial begin : cmp_model
      logic [W-1:0] a, b;
      int d;
      bit ok;
      bus.cmp_done = 1'b0; bus.cmp_less = 1'b0;
      bus.cmp_equal = 1'b0; bus.cmp_greater = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset && bus.cmp_start) begin
            a = bus.cmp_a; b = bus.cmp_b;
            d = int'($urandom_range(1, 6));
            ok = 1'b1;
            for (int k = 1; k < d; k++) begin
               @(posedge clk); #1;
               if (!reset) begin ok = 1'b0; break; end
               if (!bus.cmp_start) begin
                  check_val("cmp_start_hold", 32'(bus.cmp_start), 1);
                  ok = 1'b0; break;
               end
               check_val("cmp_a_stable", 32'(bus.cmp_a), 32'(a));
               check_val("cmp_b_stable", 32'(bus.cmp_b), 32'(b));
            end
            if (ok) begin
               bus.cmp_done = 1'b1;
               bus.cmp_less = (a < b); bus.cmp_equal = (a == b); bus.cmp_greater = (a > b);
               n_cmp++;
               @(posedge clk); #1;
               bus.cmp_done = 1'b0; bus.cmp_less = 1'b0;
               bus.cmp_equal = 1'b0; bus.cmp_greater = 1'b0;
               if (reset) check_val("cmp_start_gap", 32'(bus.cmp_start), 0);
            end
         end
      end
   end

   // Scoreboard monitor: every done pulse pops and compares one expectation.
   initial begin : monitor
      exp_t e;
      logic prev_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset && bus.done) begin
            check_val("done_single", 32'(prev_done), 0);
            check_val("busy_at_done", 32'(bus.busy), 1);
            check_val("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_val("error", 32'(bus.error), 32'(e.err));
               check_val("min1_idx", 32'(bus.min1_idx), 32'(e.i1));
               check_val("min2_idx", 32'(bus.min2_idx), 32'(e.i2));
               check_val("min1_freq", 32'(bus.min1_freq), 32'(e.f1));
               check_val("min2_freq", 32'(bus.min2_freq), 32'(e.f2));
               check_val("cmp_total", 32'(n_cmp), 32'(e.ncmp));
`ifdef MINPAIR_STATS_EN
               check_val("cmp_count", 32'(bus.cmp_count), 32'(e.ncmp));
`endif
            end
         end
         prev_done = bus.done;
      end
   end

   task automatic do_scan(input logic [N*W-1:0] fv, input logic [N-1:0] m,
                          input bit poke, output int busy_cyc);
      exp_q.push_back(model(fv, m));
      n_cmp = 0;
      bus.freq_vec = fv; bus.valid_mask = m; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.freq_vec = ~fv; bus.valid_mask = ~m;
      check_val("busy_after_start", 32'(bus.busy), 1);
      busy_cyc = 0;
      for (int c = 0; c < 400; c++) begin
         if (!bus.busy) break;
         busy_cyc++;
         bus.start = poke && (c % 3 == 1);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      check_val("scan_timeout", 32'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #1;
      check_val("idle_after", 32'(bus.busy), 0);
      check_val("sb_drained", 32'(exp_q.size()), 0);
   endtask

   function automatic logic [N*W-1:0] pack(input int f0, f1, f2, f3, f4, f5, f6, f7);
      logic [N*W-1:0] v;
      int f [N];
      f = '{f0, f1, f2, f3, f4, f5, f6, f7};
      for (int i = 0; i < N; i++) v[i*W +: W] = W'(f[i]);
      return v;
   endfunction

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [N*W-1:0] fv, base;
      logic [N-1:0]   m;
      int bc;
      bus.start = 1'b0; bus.freq_vec = '0; bus.valid_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 32'(bus.busy), 0);
      check_val("rst_done", 32'(bus.done), 0);
      check_val("rst_error", 32'(bus.error), 0);
      check_val("rst_cmp_start", 32'(bus.cmp_start), 0);
      check_val("rst_cmp_a", 32'(bus.cmp_a), 0);
      check_val("rst_min1_idx", 32'(bus.min1_idx), 0);
      check_val("rst_min2_freq", 32'(bus.min2_freq), 0);
      check_val("num_of_bits", bus.cmp_num_of_bits, 32'(W));
      reset = 1'b1;
      @(posedge clk); #1;

      base = pack(22, 5, 40, 5, 9, 100, 7, 3);
      do_scan(base, 8'hFF, 1'b0, bc);
      do_scan(base, 8'b0000_0100, 1'b0, bc);
      check_val("busy_cycles_single", 32'(bc), 1);
      fv = pack(int'($urandom_range(0, 511)), 1, 2, 3, 4, 5, 6, 0);
      fv[0 +: W] = 9'hFF; fv[7*W +: W] = 9'hEF;
      do_scan(fv, 8'b1000_0001, 1'b0, bc);
      do_scan(base, 8'h00, 1'b0, bc);
      do_scan(pack(7, 7, 7, 7, 7, 7, 7, 7), 8'hFF, 1'b1, bc);
      do_scan(pack(511, 0, 511, 0, 3, 3, 1, 1), 8'b1101_0110, 1'b1, bc);
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < N; i++) fv[i*W +: W] = W'($urandom_range(0, (t % 2 == 0) ? 15 : 511));
         m = N'($urandom);
         do_scan(fv, m, (t % 4 == 0), bc);
      end

      // Reset while the first compare is outstanding: scan abandoned, outputs cleared.
      do_scan(base, 8'hFF, 1'b0, bc);
      bus.freq_vec = base; bus.valid_mask = 8'hFF; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (bus.cmp_start) break;
         @(posedge clk); #1;
      end
      check_val("wait1_reached", 32'(bus.cmp_start), 1);
      #2 reset = 1'b0;
      #1;
      check_val("mid_rst_cmp_start", 32'(bus.cmp_start), 0);
      check_val("mid_rst_busy", 32'(bus.busy), 0);
      check_val("mid_rst_cmp_a", 32'(bus.cmp_a), 0);
      check_val("mid_rst_cmp_b", 32'(bus.cmp_b), 0);
      check_val("mid_rst_min1_idx", 32'(bus.min1_idx), 0);
      check_val("mid_rst_min2_idx", 32'(bus.min2_idx), 0);
      check_val("mid_rst_min1_freq", 32'(bus.min1_freq), 0);
      check_val("mid_rst_min2_freq", 32'(bus.min2_freq), 0);
      repeat (3) @(posedge clk);
      #1;
      check_val("mid_rst_no_done", 32'(bus.done), 0);
      reset = 1'b1;
      do_scan(base, 8'hFF, 1'b0, bc);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
